// File: rtl/image_streamer.sv
// Streams a processed IMG_W x IMG_H RGB frame out of the output image memory in
// raster order on a valid/ready interface, with end-of-frame marker and XOR checksum.
module image_streamer #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [23:0] rd_pix,
    output logic [5:0]  row,
    output logic [5:0]  col,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [23:0] m_data,
    output logic        m_last,
    output logic        busy,
    output logic        done,
    output logic [23:0] checksum
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN
    } state_e;

    localparam logic [5:0] ROW_LAST = 6'(IMG_H - 1);
    localparam logic [5:0] COL_LAST = 6'(IMG_W - 1);

    state_e      state_q, state_d;
    logic [5:0]  row_q, row_d;
    logic [5:0]  col_q, col_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;
    logic [23:0] data_q, data_d;
    logic        done_q, done_d;
    logic [23:0] csum_q, csum_d;

    logic load;
    logic xfer;
    logic at_end;

    // The output register refills whenever it is empty or being emptied this edge,
    // so m_ready only ever reaches register enables, never m_valid itself.
    assign load   = (state_q == S_STREAM) && (!valid_q || m_ready);
    assign xfer   = valid_q && m_ready;
    assign at_end = (row_q == ROW_LAST) && (col_q == COL_LAST);

    // NOTE: every _d gets its hold value first, so no path through the case leaves a latch.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
        done_d  = done_q;
        csum_d  = csum_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_STREAM;
                    row_d   = '0;
                    col_d   = '0;
                    csum_d  = '0;
                    done_d  = 1'b0;
                end
            end
            S_STREAM: begin
                if (xfer) csum_d = csum_q ^ data_q;
                if (load) begin
                    data_d  = rd_pix;
                    valid_d = 1'b1;
                    last_d  = at_end;
                    if (at_end) begin
                        row_d   = '0;
                        col_d   = '0;
                        state_d = S_DRAIN;
                    end else if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + 6'd1;
                    end else begin
                        col_d = col_q + 6'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (xfer && last_q) begin
                    csum_d  = csum_q ^ data_q;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments so every register
    // sees pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
            done_q  <= done_d;
            csum_q  <= csum_d;
        end
    end

    assign row      = row_q;
    assign col      = col_q;
    assign m_valid  = valid_q;
    assign m_last   = last_q;
    assign m_data   = data_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign checksum = csum_q;

endmodule

// File: tb/tb_image_streamer.sv
// Self-checking bench for image_streamer: raster-order frames checked against a
// queue built from the memory contents, with random backpressure and resets.
module tb_image_streamer;

    localparam int W = 64;
    localparam int H = 64;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        m_ready = 1'b0;
    logic [23:0] rd_pix;
    logic [5:0]  row, col;
    logic        m_valid, m_last, busy, done;
    logic [23:0] m_data, checksum;

    logic [23:0] mem [H][W];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign rd_pix = mem[row][col];

    image_streamer #(.IMG_W(W), .IMG_H(H)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .rd_pix   (rd_pix),
        .row      (row),
        .col      (col),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .busy     (busy),
        .done     (done),
        .checksum (checksum)
    );

    task automatic fill_pattern();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                mem[r][c] = {8'h00, 2'b00, 6'(r), 2'b00, 6'(c)};
    endtask

    task automatic fill_single();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                mem[r][c] = 24'h0;
        mem[17][42] = 24'hA5C3F0;
    endtask

    task automatic test_reset();
        logic [63:0] obs;
        rst_n = 1'b0;
        start = 1'b0;
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            obs = {row, col, m_valid, m_last, m_data, busy, done, checksum};
            n_checks++;
            if (obs !== 64'h0) begin
                n_fail++;
                $display("FAIL reset_idle: outputs=%h expected all zero", obs);
            end
        end
    endtask

    // Starts a frame from the current negedge and follows it to completion.
    task automatic run_frame(input bit rand_ready, input int glitch_at,
                             input logic [23:0] exp_cs, input string name);
        logic [23:0] expq[$];
        logic [23:0] cs_model;
        logic [23:0] hold;
        bit          stalled;
        int          idx, edges, stalls;

        expq.delete();
        cs_model = 24'h0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                expq.push_back(mem[r][c]);
                cs_model ^= mem[r][c];
            end
        idx = 0; edges = 0; stalls = 0; stalled = 1'b0; hold = 24'h0;

        start = 1'b1;
        m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (!(busy === 1'b1 && done === 1'b0 && checksum === 24'h0 && m_valid === 1'b0
              && row === 6'd0 && col === 6'd0)) begin
            n_fail++;
            $display("FAIL %s start_state: busy=%b done=%b cs=%h valid=%b row=%0d col=%0d expected 1 0 000000 0 0 0",
                     name, busy, done, checksum, m_valid, row, col);
        end

        while (idx < N && edges < 4 * N + 100) begin
            n_checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s busy_during: busy=%b done=%b at pixel %0d expected 1 0",
                         name, busy, done, idx);
            end
            if (stalled) begin
                n_checks++;
                if (m_valid !== 1'b1 || m_data !== hold) begin
                    n_fail++;
                    $display("FAIL %s stall_stable: valid=%b data=%h expected 1 %h",
                             name, m_valid, m_data, hold);
                end
            end
            m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            start   = (glitch_at >= 0 && idx == glitch_at);
            if (m_valid === 1'b1 && m_ready) begin
                n_checks++;
                if (m_data !== expq[idx] || m_last !== (idx == N - 1)) begin
                    n_fail++;
                    $display("FAIL %s pixel %0d: data=%h last=%b expected %h %b",
                             name, idx, m_data, m_last, expq[idx], idx == N - 1);
                end
                idx++;
            end else if (m_valid === 1'b1) begin
                stalls++;
            end
            stalled = (m_valid === 1'b1) && !m_ready;
            hold    = m_data;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        start = 1'b0;

        n_checks++;
        if (idx < N) begin
            n_fail++;
            $display("FAIL %s timeout: %0d pixels received expected %0d", name, idx, N);
        end else begin
            if (!(done === 1'b1 && busy === 1'b0 && m_valid === 1'b0 && m_last === 1'b0
                  && row === 6'd0 && col === 6'd0)) begin
                n_fail++;
                $display("FAIL %s end_state: done=%b busy=%b valid=%b last=%b row=%0d col=%0d expected 1 0 0 0 0 0",
                         name, done, busy, m_valid, m_last, row, col);
            end
            n_checks++;
            if (checksum !== cs_model || checksum !== exp_cs) begin
                n_fail++;
                $display("FAIL %s checksum: got %h expected %h", name, checksum, exp_cs);
            end
            n_checks++;
            if (edges != N + 1 + stalls) begin
                n_fail++;
                $display("FAIL %s frame_edges: got %0d expected %0d (stalls %0d)",
                         name, edges, N + 1 + stalls, stalls);
            end
        end
    endtask

    task automatic test_full_frame();
        fill_pattern();
        run_frame(1'b0, -1, 24'h000000, "full_frame");
    endtask

    task automatic test_checksum();
        fill_single();
        run_frame(1'b0, -1, 24'hA5C3F0, "checksum");
    endtask

    task automatic test_backpressure();
        fill_pattern();
        run_frame(1'b1, 100, 24'h000000, "backpressure");
    endtask

    task automatic test_reset_mid();
        int idx = 0;
        int guard = 0;
        fill_pattern();
        start = 1'b1;
        m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        while (idx < 2000 && guard < 5000) begin
            if (m_valid === 1'b1) idx++;
            guard++;
            @(posedge clk);
            @(negedge clk);
        end
        n_checks++;
        if (m_valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid pre: valid=%b busy=%b expected 1 1", m_valid, busy);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (!(m_valid === 1'b0 && busy === 1'b0 && done === 1'b0 && row === 6'd0
              && col === 6'd0 && checksum === 24'h0 && m_data === 24'h0)) begin
            n_fail++;
            $display("FAIL reset_mid async: valid=%b busy=%b done=%b row=%0d col=%0d cs=%h data=%h expected all zero",
                     m_valid, busy, done, row, col, checksum, m_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(1'b0, -1, 24'h000000, "after_reset");
    endtask

    initial begin
        fill_pattern();
        test_reset();
        test_full_frame();
        test_checksum();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/image_streamer.md
# image_streamer

Output stage placed directly downstream of the image processing block. Once processing is finished, it reads the processed 64x64 RGB image out of the output image memory in raster order. Pixels leave on a valid/ready stream with an end-of-frame marker and a running XOR checksum. The stream sustains one pixel per cycle under continuous `m_ready` and stalls without loss under backpressure.

## Interface
Parameters:
- `IMG_W`, 64, pixels per row (1..64)
- `IMG_H`, 64, rows per frame (1..64)

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset; one clock, asynchronous, active-low
- `start`  in  1  frame request, sampled each rising edge; driven from the processing block's final done flag
- `rd_pix`  in  24  output image memory data at [`row`,`col`], combinational read, same cycle (R 23:16, G 15:8, B 7:0)
- `row`, `col`  out  6 each  memory read address
- `m_valid`  out  1  stream data valid
- `m_ready`  in  1  downstream accepts
- `m_data`  out  24  pixel
- `m_last`  out  1  high with the final pixel of the frame
- `busy`  out  1  high in STREAM and DRAIN
- `done`  out  1  frame fully transferred; level, held until the next accepted `start`
- `checksum`  out  24  XOR of all pixels handshaken this frame

## Operation
- States:
  - IDLE: waiting for a frame request.
  - STREAM: fetching pixels from memory.
  - DRAIN: the last pixel is loaded and waiting to be accepted.
- Handshake:
  - A transfer occurs on an edge where `m_valid && m_ready`.
  - `m_data` and `m_last` stay stable while `m_valid && !m_ready`.
  - `m_valid` never drops without a transfer.
- Load condition: `load = (state==STREAM) && (!m_valid || m_ready)`.
- On load:
  - `m_data <= rd_pix`, `m_valid <= 1`.
  - `m_last <= (row==IMG_H-1 && col==IMG_W-1)`.
  - The address advances: `col+1`, or `col=0, row+1` at `IMG_W-1`.
- Transitions:
  - IDLE -> STREAM when `start`=1. On the same edge: `row`,`col`,`checksum` <= 0 and `done` <= 0.
  - STREAM -> DRAIN on the load of the last pixel. The address wraps to 0,0.
  - DRAIN -> IDLE on the transfer with `m_last`=1. On the same edge: `m_valid`,`m_last` <= 0 and `done` <= 1.
  - In STREAM, a transfer with no load (impossible by the load rule) is not a case to handle. A transfer and a load on the same edge is the normal full-throughput case.
- `checksum <= checksum ^ m_data` on every transfer. The final value is valid when `done` rises and holds until the next `start`.
- `start` is ignored while `busy`=1. A `start` held high in IDLE after `done` begins a new frame.
- `row`/`col` are 0 in IDLE and DRAIN.

## Timing
- Reset (async assert, released synchronously by the environment):
  - State IDLE.
  - `row`=`col`=0, `m_valid`=0, `m_last`=0, `m_data`=0.
  - `busy`=0, `done`=0, `checksum`=0.
- Reset asserted mid-frame aborts immediately to the reset values. The partial frame is not resumed, and `done` stays 0.
- Latency, with `start` sampled at edge E0:
  - `busy`=1 after E0.
  - First pixel loaded at E1; `m_valid`=1 after E1.
- With `m_ready` held at 1:
  - Pixel k transfers at edge E(k+2).
  - The last pixel (N = IMG_W*IMG_H) transfers at E(N+1).
  - `done`=1 and `busy`=0 after E(N+1).
  - For 64x64, the frame takes 4097 edges after the start edge.
- Each cycle of `m_ready`=0 while `m_valid`=1 adds exactly one cycle. No pixel is skipped or duplicated.
- `m_ready` is never used combinationally toward `m_valid`. `row`/`col` depend on registered state only.

## Test plan
- Reset then idle:
  - Stimulus: `rst_n`=0 then 1, `start`=0 for 10 cycles.
  - Response: all outputs stay 0.
- Full frame, `m_ready`=1:
  - Stimulus: memory[r][c] = {8'h00, 2'b0,r, 2'b0,c}.
  - Response: 4096 transfers in raster order. `m_last` only on pixel 4095 (24'h003F3F). `done` rises at the 4097th edge after start. `checksum`=24'h000000.
- Checksum:
  - Stimulus: all memory zero except [17][42] = 24'hA5C3F0.
  - Response: `checksum`=24'hA5C3F0 at `done`.
- Backpressure:
  - Stimulus: `m_ready` pseudo-random at 50%.
  - Response: `m_data` is stable during stalls. The received sequence matches the full-frame case exactly, and the total cycles = 4097 + stall cycles.
- Start during busy:
  - Stimulus: pulse `start` at pixel 100.
  - Response: ignored; the frame completes normally. A `start` after `done` clears `done` and `checksum` and restarts at 0,0.
- Reset mid-frame:
  - Stimulus: `rst_n`=0 at pixel 2000 while `m_valid`=1.
  - Response: `m_valid`, `busy` and `done` drop to 0 asynchronously. The next `start` streams from 0,0.
